rr_ring_arbiter: RTL
====================

Name: rr_ring_arbiter

Overview:
Round-robin arbiter sharing one downstream resource among N requesters. Priority is held in a one-hot ring pointer that rotates past each winner, so every active requester gets service within N grants. Grants are registered and one-hot. The owner holds the grant until it drops its request. Sits between requester blocks and a shared datapath such as a bus port or counter bank.

Parameters:
N, 4, number of requesters (2..16)
HOLD_MAX, 16, max consecutive grant cycles before forced handoff (used only with ARB_TIMEOUT_EN; >=1)
IDW, $clog2(N), width of gnt_id (derived, localparam)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
clr  in  1  synchronous clear: same effect as reset, on the next edge
req  in  N  request per requester, level; bit i = requester i
gnt  out  N  one-hot grant (all-zero when idle), registered
gnt_vld  out  1  OR of gnt, registered
gnt_id  out  IDW  binary index of granted requester; 0 when idle
ptr  out  N  one-hot priority pointer; the bit set is the highest-priority requester
preempt  out  1  one-cycle pulse when a grant was revoked by timeout (tied 0 without ARB_TIMEOUT_EN)

Behaviour:
- Reset (async) or clr (sync): gnt=0, gnt_vld=0, gnt_id=0, ptr=1 (requester 0 highest), preempt=0, hold counter=0, state=IDLE.
- States: IDLE (no owner) and OWN (gnt holds one bit).
- Arbitration function: search req starting at the ptr bit, ascending index, wrapping from N-1 to 0. The first set bit wins. With req=0 there is no winner.
- IDLE: on an edge where a winner exists, gnt <= onehot(winner), gnt_id <= winner, gnt_vld <= 1, ptr <= onehot((winner+1) mod N), go to OWN. Latency: 1 cycle from req sampled high to gnt high.
- OWN, req[owner]=1: gnt, gnt_id and ptr unchanged. Other requests are ignored.
- OWN, req[owner]=0 at an edge: re-arbitrate in the same edge, excluding the owner.
  - Winner found: gnt moves to the winner with no idle gap, ptr <= winner+1.
  - No winner: gnt <= 0, gnt_id <= 0, gnt_vld <= 0, go to IDLE. ptr unchanged.
- The owner's own req bit is masked during handoff arbitration. Because ptr has already passed it, the owner can regain the grant only after the other pending requesters, or when it is alone.
- ptr wrap: winner N-1 -> ptr=1 (bit 0).
- ptr is always exactly one-hot. gnt is always zero or one-hot. gnt_vld == |gnt, and gnt_id is consistent with gnt, every cycle.
- A req bit rising and falling between edges is never seen; only sampled values matter.
- rst_n asserted mid-grant: outputs clear immediately (asynchronously) and no handoff occurs. After release, arbitration restarts from ptr=1.
- clr has priority over all other next-state logic.

Optional Feature:
ARB_TIMEOUT_EN
- Defined: a hold counter counts cycles in OWN for the current owner.
  - It resets to 0 on every new grant and saturates at HOLD_MAX.
  - Forced handoff happens on the edge where the counter == HOLD_MAX-1, the owner still requests, and any other requester is active. On that edge, arbitrate excluding the owner, move gnt to the winner, advance ptr, and pulse preempt=1 for one cycle.
  - If no other requester is active, the owner keeps the grant and the counter holds at HOLD_MAX. Preemption then happens on the first edge another request is seen.
- Undefined: no counter, grant held indefinitely, preempt tied to 0.

Test Plan:
- Reset release, req=0 for 5 cycles -> gnt=0, gnt_vld=0, gnt_id=0, ptr=4'b0001, every cycle.
- req=4'b0100 at cycle k -> gnt=4'b0100, gnt_id=2, ptr=4'b1000 at k+1. Drop req -> gnt=0, IDLE, ptr stays 4'b1000.
- From reset, req=4'b1111 and each owner drops req for one cycle after owning 2 cycles -> grant order 0,1,2,3,0. Handoffs have no idle gap and ptr walks 0010,0100,1000,0001.
- Owner 3 while req=4'b1001, owner drops -> gnt=4'b0001 next edge, ptr=4'b0010 (wrap check). Owner 0 re-raises immediately with req=4'b1001 -> requester 3 served before 0.
- clr pulsed while gnt=4'b0010 -> next edge gnt=0, ptr=4'b0001. With req=4'b0010 still high, the following edge gives gnt=4'b0010.
- ARB_TIMEOUT_EN, HOLD_MAX=4, req=4'b0011 held constant -> gnt alternates 0001/0010 every 4 cycles with a preempt pulse at each switch. With req=4'b0001 alone -> grant held, preempt never asserted.

Source files
------------

// File: rtl/rr_ring_arbiter.sv
// rr_ring_arbiter: round-robin arbiter with a one-hot ring pointer and registered one-hot grants.
// Optional forced handoff after HOLD_MAX owned cycles when built with `define ARB_TIMEOUT_EN.
module rr_ring_arbiter #(
  parameter int N = 4,
  parameter int HOLD_MAX = 16,
  localparam int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic           gnt_vld,
  output logic [IDW-1:0] gnt_id,
  output logic [N-1:0]   ptr,
  output logic           preempt
);
  typedef enum logic {IDLE, OWN} state_t;
  state_t state, state_nxt;
  logic [N-1:0] gnt_nxt, ptr_nxt, win_oh, mreq, rot;
  logic [IDW-1:0] id_nxt, pidx, widx;
  logic vld_nxt, found, take, owner_req, force_ho;

  if (N < 2 || N > 16 || HOLD_MAX < 1) begin : g_cfg_chk
    $error("rr_ring_arbiter: unsupported N or HOLD_MAX");
  end

  // The owner is masked so a handoff can only pick someone else.
  assign mreq = req & ~gnt;
  assign owner_req = |(req & gnt);

  always_comb begin
    pidx = '0;
    for (int i = 0; i < N; i++) if (ptr[i]) pidx = IDW'(i);
    rot = N'({mreq, mreq} >> pidx);
    found = 1'b0;
    widx = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        widx = IDW'((int'(pidx) + k) % N);
      end
    end
    win_oh = N'(1) << widx;
  end

  assign take = !clr && found && (state == IDLE || !owner_req || force_ho);

  always_comb begin
    state_nxt = state;
    gnt_nxt = gnt;
    id_nxt = gnt_id;
    vld_nxt = gnt_vld;
    ptr_nxt = ptr;
    if (clr) begin
      state_nxt = IDLE;
      gnt_nxt = '0;
      id_nxt = '0;
      vld_nxt = 1'b0;
      ptr_nxt = N'(1);
    end else if (take) begin
      state_nxt = OWN;
      gnt_nxt = win_oh;
      id_nxt = widx;
      vld_nxt = 1'b1;
      ptr_nxt = {win_oh[N-2:0], win_oh[N-1]};
    end else if (state == OWN && !owner_req) begin
      state_nxt = IDLE;
      gnt_nxt = '0;
      id_nxt = '0;
      vld_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      gnt <= '0;
      gnt_id <= '0;
      gnt_vld <= 1'b0;
      ptr <= N'(1);
    end else begin
      state <= state_nxt;
      gnt <= gnt_nxt;
      gnt_id <= id_nxt;
      gnt_vld <= vld_nxt;
      ptr <= ptr_nxt;
    end

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(HOLD_MAX + 1);
  logic [CW-1:0] cnt;
  // Counter saturates at HOLD_MAX, so a lone owner is preempted on the first edge a rival shows up.
  assign force_ho = state == OWN && owner_req && found && cnt >= CW'(HOLD_MAX - 1);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      preempt <= 1'b0;
    end else begin
      preempt <= !clr && force_ho;
      cnt <= (clr || take) ? '0 : (state == OWN && cnt != CW'(HOLD_MAX)) ? cnt + 1'b1 : cnt;
    end
`else
  assign force_ho = 1'b0;
  assign preempt = 1'b0;
`endif
endmodule
